// File: rtl/fetch_unit.sv
// ==== fetch_unit: PC register and fetch stage with a 2-entry (out + skid) decode buffer ====
// Rev 1.0
`default_nettype none

module fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] instruction_address,
  input  logic [31:0]       instruction_in,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam logic [ADDR_W-1:0] c_pc_mask = ADDR_W'(MEM_DEPTH - 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              skid_valid_q, skid_valid_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

  logic       deq;
  logic       issue;
  logic [1:0] occ;

  always_comb begin
    deq   = out_valid_q & instr_ready;
    // Slots already committed for the next cycle; an issue is allowed only if one stays free.
    occ   = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q} - {1'b0, deq};
    issue = !halt && !redirect_valid && (occ < 2'd2);

    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (redirect_valid) begin
      pc_d         = redirect_target & c_pc_mask;
      pend_d       = 1'b0;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      pend_d = issue;
      if (issue) begin
        pend_pc_d = pc_q;
        pc_d      = (pc_q + ADDR_W'(1)) & c_pc_mask;
      end
      if (deq) begin
        out_valid_d = 1'b0;
      end
      if (!out_valid_d && skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end
      // Arriving data is always younger than whatever sits in the skid register.
      if (pend_q) begin
        if (!out_valid_d) begin
          out_valid_d = 1'b1;
          out_instr_d = instruction_in;
          out_pc_d    = pend_pc_q;
        end else begin
          skid_valid_d = 1'b1;
          skid_instr_d = instruction_in;
          skid_pc_d    = pend_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign instruction_address = pc_q;
  assign instr_valid         = out_valid_q;
  assign instr_out           = out_instr_q;
  assign instr_pc            = out_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ==== tb_fetch_unit: randomized + directed bench for fetch_unit against a queue-level model ====
// Rev 1.0
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instruction_address;
  logic [31:0] instruction_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  logic [31:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_q[$];

  fetch_unit #(
    .ADDR_W   (32),
    .RESET_PC (32'd0),
    .MEM_DEPTH(64)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .halt               (halt),
    .redirect_valid     (redirect_valid),
    .redirect_target    (redirect_target),
    .instruction_address(instruction_address),
    .instruction_in     (instruction_in),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .instr_out          (instr_out),
    .instr_pc           (instr_pc)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory.
  always @(posedge clk) begin
    instruction_in <= mem[instruction_address[5:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'd0;
    m_pend = 1'b0;
    m_q.delete();
  endtask

  // Buffered entries are a program-ordered queue of PCs; data is always mem[pc].
  task automatic model_edge(input bit h, input bit r, input logic [31:0] t, input bit rd);
    int occ;
    bit d;
    if (r) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc   = t % 64;
    end else begin
      d   = (m_q.size() > 0) && rd;
      occ = m_q.size() + int'(m_pend) - int'(d);
      if (d) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_pc);
      if (!h && occ < 2) begin
        m_pend    = 1'b1;
        m_pend_pc = m_pc;
        m_pc      = (m_pc + 1) % 64;
      end else begin
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] p;
    check_val("addr", instruction_address, m_pc);
    check_val("valid", {31'd0, instr_valid}, {31'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      p = m_q[0];
      check_val("pc", instr_pc, p);
      check_val("instr", instr_out, mem[p[5:0]]);
    end
  endtask

  task automatic cycle(input bit h, input bit r, input logic [31:0] t, input bit rd);
    halt            = h;
    redirect_valid  = r;
    redirect_target = t;
    instr_ready     = rd;
    model_edge(h, r, t, rd);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h3C01003F;
    mem[1] = 32'h3C020043;
    mem[2] = 32'h3C030020;
    mem[3] = 32'h00221002;

    rst             = 1'b0;
    halt            = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    instr_ready     = 1'b1;
    model_reset();

    @(negedge clk);
    check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("rst_addr", instruction_address, 32'd0);
    check_val("rst_instr", instr_out, 32'd0);
    check_val("rst_pc", instr_pc, 32'd0);
    rst = 1'b1;

    // Startup stream
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    // Backpressure for 4 cycles, then release
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    // Fill buffer with pc reaching 8, then redirect to 2 while full
    cycle(1'b0, 1'b1, 32'd6, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
    check_val("full_addr", instruction_address, 32'd8);
    cycle(1'b0, 1'b1, 32'd2, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    // Wrap
    cycle(1'b0, 1'b1, 32'd63, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    // Halt for 3 cycles, then resume
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    // Redirect coinciding with a dequeue
    cycle(1'b0, 1'b1, 32'd40, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom,
            $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset between edges while streaming
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_valid", {31'd0, instr_valid}, 32'd0);
    check_val("arst_addr", instruction_address, 32'd0);
    check_val("arst_instr", instr_out, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0, $urandom_range(0, 1) == 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch stage that sits directly upstream of instruction_memory and drives its instruction_address.
- Captures the memory's registered instruction_out one cycle later and presents it to decode through a valid/ready handshake with a 2-entry buffer (output register plus skid register).
- Handles jump/branch redirects from execute by squashing in-flight and buffered fetches.

Parameters:
ADDR_W, 32, width of PC, instruction_address and redirect_target
RESET_PC, 0, PC value loaded on reset (word index)
MEM_DEPTH, 64, instruction memory depth in words; power of two; PC wraps modulo MEM_DEPTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
halt  input  1  1 = issue no new fetches; in-flight fetch still completes
redirect_valid  input  1  1 = load PC from redirect_target at this edge, flush pipeline
redirect_target  input  ADDR_W  new PC (word index)
instruction_address  output  ADDR_W  to instruction_memory; equals PC register
instruction_in  input  32  from instruction_memory instruction_out (valid the cycle after issue)
instr_valid  output  1  output register holds an instruction
instr_ready  input  1  decode accepts the instruction this edge
instr_out  output  32  instruction word
instr_pc  output  ADDR_W  word address of instr_out

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, pend=0, out_valid=0, skid_valid=0, instr_out=0, instr_pc=0. Outputs reflect this immediately, without waiting for a clock edge.
- The memory samples address at edge E and returns data after E, so a fetch issued at E is in instruction_in during the cycle E..E+1.
- Internal state:
  - pend: a fetch is in flight.
  - pend_pc: address of the in-flight fetch.
  - out (valid/instr/pc): output register.
  - skid (valid/instr/pc): skid register.
- Dequeue: deq = out_valid & instr_ready.
- Issue: issue = !halt & !redirect_valid & ((out_valid + skid_valid + pend - deq) < 2).
  - When issue: pend<=1, pend_pc<=pc, pc<=(pc+1) mod MEM_DEPTH.
  - Otherwise: pend<=0, pc holds.
- Capture (when pend=1 and no redirect), instruction_in/pend_pc go to:
  - out, if out is empty after deq and skid is empty;
  - otherwise skid.
- Refill: on deq with skid_valid=1, skid moves to out. Any arriving data then goes into skid, or into out if out would otherwise be empty.
- Ordering is strictly program order: skid is always older than arriving data.
- Redirect (highest priority, overrides halt and deq):
  - At that edge: pc<=redirect_target mod MEM_DEPTH; pend, out_valid and skid_valid all <=0.
  - instr_out/instr_pc hold their old values (don't-care while invalid).
  - The first fetch from the target issues at the next edge.
- Latency: issue edge -> instr_valid high after the next edge (2 edges). Steady-state throughput with instr_ready=1 is 1 instruction/cycle.
- Wrap-around: pc=MEM_DEPTH-1 increments to 0. No error flag.
- Full condition: out and skid both valid with instr_ready=0 -> no issue; pc holds; no data lost.
- Halt asserted mid-stream: the in-flight fetch is captured; issue resumes on the edge after halt falls.
- Simultaneous redirect with deq: the redirect wins; the accepted instruction still counts as consumed by decode.
- Reset during operation: all state clears asynchronously. Fetch restarts from RESET_PC on the first edge after rst=1.

Test Plan:
- Reset release, memory words 0..3 = 0x3C01003F,0x3C020043,0x3C030020,0x00221002, instr_ready=1 -> instr_valid rises 2 edges after the first issue; instr_pc 0,1,2,3 on consecutive cycles with matching words.
- Backpressure: drop instr_ready for 4 cycles mid-stream -> instr_out/instr_pc stay stable, instruction_address stops advancing after the skid fills. On release, the sequence continues with no gap, loss or duplicate.
- Redirect: redirect_valid=1, target=2 while pc=8 and out/skid full -> instr_valid=0 next cycle; instruction_address=2; next valid instr_pc=2.
- Wrap: redirect to 63 with instr_ready=1 -> instr_pc sequence 63,0,1.
- Halt: halt=1 for 3 cycles -> the one in-flight instruction is delivered, then instr_valid=0 and pc is frozen. Deasserting halt resumes from the frozen pc.
- Async reset: pull rst low between clock edges while streaming -> instr_valid=0 and instruction_address=RESET_PC immediately, before any clock edge.
